// File: rtl/emif_csr_pkg.sv
//------------------------------------------------------------------------------
// Module   : emif_csr_pkg
// Purpose  : Shared types and constants for the EMIF CSR / channel-reset
//            block: DFH layout, register offsets, feature identity and the
//            per-channel reset FSM state encoding.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package emif_csr_pkg;

  // Device Feature Header layout, MSB first
  typedef struct packed {
    logic [3:0]  feature_type;
    logic [7:0]  rsvd_hi;
    logic [3:0]  minor_rev;
    logic [6:0]  rsvd_lo;
    logic        eol;
    logic [23:0] next_offset;
    logic [3:0]  major_ver;
    logic [11:0] feature_id;
  } t_dfh;

  // Register byte offsets (64-bit aligned)
  localparam logic [7:0] c_addr_dfh     = 8'h00;
  localparam logic [7:0] c_addr_status  = 8'h08;
  localparam logic [7:0] c_addr_cap     = 8'h10;
  localparam logic [7:0] c_addr_control = 8'h18;

  // Feature identity
  localparam logic [11:0] c_feature_id   = 12'h009;
  localparam logic [3:0]  c_feature_type = 4'h3;
  localparam logic [3:0]  c_major_ver    = 4'h1;

  // Per-channel reset sequencer states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RST      = 2'd1,
    ST_WAIT_CAL = 2'd2
  } t_ch_state;

  // Assemble the DFH word from the two configurable fields
  function automatic logic [63:0] dfh_pack(input logic eol, input logic [23:0] next_offset);
    t_dfh d;
    d.feature_type = c_feature_type;
    d.rsvd_hi      = 8'h0;
    d.minor_rev    = 4'h0;
    d.rsvd_lo      = 7'h0;
    d.eol          = eol;
    d.next_offset  = next_offset;
    d.major_ver    = c_major_ver;
    d.feature_id   = c_feature_id;
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/emif_ch_rst_fsm.sv
//------------------------------------------------------------------------------
// Module   : emif_ch_rst_fsm
// Purpose  : One EMIF channel reset sequencer: drives a fixed-length active-low
//            reset pulse, then waits for calibration to pass or fail.
//            Optional calibration timeout: EMIF_CSR_CAL_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module emif_ch_rst_fsm
  import emif_csr_pkg::*;
#(
  parameter int          RST_PULSE_CYCLES   = 16,
  parameter logic [31:0] CAL_TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,        // accepted only while idle
  input  logic cal_success,  // already synchronised
  input  logic cal_fail,     // already synchronised
  output logic ch_rst_n,
  output logic busy,
  output logic timeout       // single-cycle pulse on calibration timeout
);

  localparam int              c_pw         = $clog2(RST_PULSE_CYCLES);
  localparam logic [c_pw-1:0] c_pulse_last = c_pw'(RST_PULSE_CYCLES - 1);

  t_ch_state       r_state;
  t_ch_state       w_state_next;
  logic            r_out_en;     // holds the channel reset low until the first edge out of reset
  logic [c_pw-1:0] r_pulse_cnt;
  logic            w_pulse_done;
  logic            w_cal_done;
  logic            w_to_hit;

  assign w_pulse_done = (r_pulse_cnt == c_pulse_last);
  assign w_cal_done   = cal_success | cal_fail;

  // State register and reset-release flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_out_en <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_out_en <= 1'b1;
    end
  end

  // Pulse-length counter, counts only while the reset pulse is active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pulse_cnt <= '0;
    end else if (r_state == ST_RST) begin
      r_pulse_cnt <= r_pulse_cnt + c_pw'(1);
    end else begin
      r_pulse_cnt <= '0;
    end
  end

`ifdef EMIF_CSR_CAL_TIMEOUT_EN
  logic [31:0] r_to_cnt;

  // Calibration wait counter, restarts on every entry to WAIT_CAL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (r_state == ST_WAIT_CAL) begin
      r_to_cnt <= r_to_cnt + 32'd1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  // A calibration result in the final cycle still wins over the timeout
  assign w_to_hit = (r_state == ST_WAIT_CAL) && !w_cal_done &&
                    (r_to_cnt == CAL_TIMEOUT_CYCLES - 32'd1);
`else
  logic w_unused_to;
  assign w_unused_to = ^CAL_TIMEOUT_CYCLES;
  assign w_to_hit    = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (start)                 w_state_next = ST_RST;
      ST_RST:      if (w_pulse_done)          w_state_next = ST_WAIT_CAL;
      ST_WAIT_CAL: if (w_cal_done || w_to_hit) w_state_next = ST_IDLE;
      default:                                w_state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    ch_rst_n = r_out_en && (r_state != ST_RST);
    busy     = (r_state != ST_IDLE);
    timeout  = w_to_hit;
  end

endmodule

`default_nettype wire

// File: rtl/emif_csr_mc.sv
//------------------------------------------------------------------------------
// Module   : emif_csr_mc
// Purpose  : CSR block for a multi-channel EMIF: DFH / STATUS / CAPABILITY /
//            CONTROL registers, calibration-status synchronisers and one reset
//            sequencer per channel.
//            Optional calibration timeout: EMIF_CSR_CAL_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module emif_csr_mc
  import emif_csr_pkg::*;
#(
  parameter int          NUM_CH             = 2,
  parameter logic [7:0]  CH_PRESENT         = 8'h03,
  parameter int          RST_PULSE_CYCLES   = 16,
  parameter logic [31:0] CAL_TIMEOUT_CYCLES = 32'd1_000_000,
  parameter logic [23:0] DFH_NEXT_OFFSET    = 24'h00B000,
  parameter logic        DFH_EOL            = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              csr_write,
  input  logic              csr_read,
  input  logic [7:0]        csr_addr,
  input  logic [63:0]       csr_wdata,
  output logic [63:0]       csr_rdata,
  output logic              csr_rvalid,
  input  logic [NUM_CH-1:0] cal_success_i,
  input  logic [NUM_CH-1:0] cal_fail_i,
  output logic [NUM_CH-1:0] mem_ch_rst_n
);

  localparam logic [NUM_CH-1:0] c_present = CH_PRESENT[NUM_CH-1:0];
  localparam logic [63:0]       c_dfh     = dfh_pack(DFH_EOL, DFH_NEXT_OFFSET);
  localparam logic [63:0]       c_cap     = {24'h0, 8'(NUM_CH), 24'h0, 8'(c_present)};

  logic [NUM_CH-1:0] r_succ_meta, r_succ_sync;
  logic [NUM_CH-1:0] r_fail_meta, r_fail_sync;
  logic [NUM_CH-1:0] w_start;
  logic [NUM_CH-1:0] w_busy;
  logic [NUM_CH-1:0] w_to_pulse;
  logic [NUM_CH-1:0] w_sticky;
  logic [7:0]        w_addr_al;
  logic              w_ctrl_wr;
  logic [63:0]       w_status;
  logic [63:0]       w_rd_mux;
  logic [63:0]       r_rdata;
  logic              r_rvalid;
  logic              w_unused_bits;

  assign w_addr_al     = {csr_addr[7:3], 3'b000};
  assign w_ctrl_wr     = csr_write && (w_addr_al == c_addr_control);
  assign w_unused_bits = ^{csr_addr[2:0], csr_wdata};

  // Two-flop synchronisers for the asynchronous calibration levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_succ_meta <= '0;
      r_succ_sync <= '0;
      r_fail_meta <= '0;
      r_fail_sync <= '0;
    end else begin
      r_succ_meta <= cal_success_i;
      r_succ_sync <= r_succ_meta;
      r_fail_meta <= cal_fail_i;
      r_fail_sync <= r_fail_meta;
    end
  end

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      // Absent channels never see a start request
      assign w_start[i] = w_ctrl_wr && csr_wdata[i] && c_present[i];

      emif_ch_rst_fsm #(
        .RST_PULSE_CYCLES   (RST_PULSE_CYCLES),
        .CAL_TIMEOUT_CYCLES (CAL_TIMEOUT_CYCLES)
      ) u_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (w_start[i]),
        .cal_success (r_succ_sync[i]),
        .cal_fail    (r_fail_sync[i]),
        .ch_rst_n    (mem_ch_rst_n[i]),
        .busy        (w_busy[i]),
        .timeout     (w_to_pulse[i])
      );
    end
  endgenerate

`ifdef EMIF_CSR_CAL_TIMEOUT_EN
  logic [NUM_CH-1:0] r_sticky;
  logic              w_clr;

  assign w_clr = w_ctrl_wr && csr_wdata[63];

  // Sticky timeout flags; a new timeout beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= w_to_pulse | (r_sticky & ~{NUM_CH{w_clr}});
    end
  end

  assign w_sticky = r_sticky;
`else
  logic w_unused_to;
  assign w_unused_to = ^w_to_pulse;
  assign w_sticky    = '0;
`endif

  assign w_status = {32'h0, 8'(w_sticky), 8'(w_busy), 8'(r_fail_sync), 8'(r_succ_sync)};

  // Read decode on pre-write state
  always_comb begin
    w_rd_mux = 64'h0;
    case (w_addr_al)
      c_addr_dfh:    w_rd_mux = c_dfh;
      c_addr_status: w_rd_mux = w_status;
      c_addr_cap:    w_rd_mux = c_cap;
      default:       w_rd_mux = 64'h0;
    endcase
  end

  // Registered read response; data holds until the next read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 64'h0;
    end else begin
      r_rvalid <= csr_read;
      if (csr_read) begin
        r_rdata <= w_rd_mux;
      end
    end
  end

  assign csr_rdata  = r_rdata;
  assign csr_rvalid = r_rvalid;

endmodule

`default_nettype wire

// File: tb/tb_emif_csr_mc.sv
//------------------------------------------------------------------------------
// Module   : tb_emif_csr_mc
// Purpose  : Self-checking bench for emif_csr_mc: directed scenarios followed
//            by random CSR traffic, compared against a cycle-level model.
//            Timeout expectations follow EMIF_CSR_CAL_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_emif_csr_mc;

  localparam int NUM_CH    = 2;
  localparam int RST_PULSE = 16;
  localparam int TO_CYC    = 100;
`ifdef EMIF_CSR_CAL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              csr_write = 1'b0;
  logic              csr_read = 1'b0;
  logic [7:0]        csr_addr = 8'h0;
  logic [63:0]       csr_wdata = 64'h0;
  logic [63:0]       csr_rdata;
  logic              csr_rvalid;
  logic [NUM_CH-1:0] cal_s = '0;
  logic [NUM_CH-1:0] cal_f = '0;
  logic [NUM_CH-1:0] mem_ch_rst_n;

  always #5 clk = ~clk;

  emif_csr_mc #(
    .NUM_CH             (NUM_CH),
    .CH_PRESENT         (8'h03),
    .RST_PULSE_CYCLES   (RST_PULSE),
    .CAL_TIMEOUT_CYCLES (32'd100),
    .DFH_NEXT_OFFSET    (24'h00B000),
    .DFH_EOL            (1'b0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .csr_write     (csr_write),
    .csr_read      (csr_read),
    .csr_addr      (csr_addr),
    .csr_wdata     (csr_wdata),
    .csr_rdata     (csr_rdata),
    .csr_rvalid    (csr_rvalid),
    .cal_success_i (cal_s),
    .cal_fail_i    (cal_f),
    .mem_ch_rst_n  (mem_ch_rst_n)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct { logic [63:0] d; time t_due; } rd_exp_t;
  rd_exp_t exp_q[$];

  // Reference model: remaining pulse cycles, calibration wait, sync pipelines
  int          low_left [NUM_CH];
  bit          waiting  [NUM_CH];
  int          wait_cyc [NUM_CH];
  bit          sticky   [NUM_CH];
  bit          s1 [NUM_CH], s2 [NUM_CH], f1 [NUM_CH], f2 [NUM_CH];
  bit          released;
  logic [NUM_CH-1:0] g_cs = '0, g_cf = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [63:0] model_read(input logic [7:0] a);
    logic [63:0] st;
    st = 64'h0;
    case (a & 8'hF8)
      8'h00: st = 64'h3000_0000_B000_1009;
      8'h08: for (int c = 0; c < NUM_CH; c++) begin
               st[c]      = s2[c];
               st[8 + c]  = f2[c];
               st[16 + c] = (low_left[c] > 0) || waiting[c];
               st[24 + c] = sticky[c];
             end
      8'h10: st = 64'h0000_0002_0000_0003;
      default: st = 64'h0;
    endcase
    return st;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      low_left[c] = 0; waiting[c] = 0; wait_cyc[c] = 0; sticky[c] = 0;
      s1[c] = 0; s2[c] = 0; f1[c] = 0; f2[c] = 0;
    end
    released = 0;
  endtask

  task automatic model_edge(input bit wr, input logic [7:0] a, input logic [63:0] wd);
    bit ctrl, to_set;
    ctrl = wr && ((a & 8'hF8) == 8'h18);
    for (int c = 0; c < NUM_CH; c++) begin
      to_set = 0;
      if (low_left[c] > 0) begin
        low_left[c]--;
        if (low_left[c] == 0) begin waiting[c] = 1; wait_cyc[c] = 0; end
      end else if (waiting[c]) begin
        if (s2[c] || f2[c]) waiting[c] = 0;
        else if (TO_EN && wait_cyc[c] == TO_CYC - 1) begin waiting[c] = 0; to_set = 1; end
        else wait_cyc[c]++;
      end else if (ctrl && wd[c]) begin
        low_left[c] = RST_PULSE;
      end
      if (to_set) sticky[c] = 1;
      else if (ctrl && TO_EN && wd[63]) sticky[c] = 0;
      s2[c] = s1[c]; s1[c] = cal_s[c];
      f2[c] = f1[c]; f1[c] = cal_f[c];
    end
    released = 1;
  endtask

  // One bus cycle: drive at negedge, record expected read, advance model at posedge
  task automatic step(input bit rd, input bit wr, input logic [7:0] a, input logic [63:0] wd);
    @(negedge clk);
    csr_read = rd; csr_write = wr; csr_addr = a; csr_wdata = wd;
    cal_s = g_cs; cal_f = g_cf;
    if (rd) exp_q.push_back('{model_read(a), $time + 11});
    @(posedge clk);
    if (rst_n) model_edge(wr, a, wd);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 8'h08, 64'h0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0; csr_read = 1'b0; csr_write = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_edge(1'b0, 8'h0, 64'h0);
  endtask

  // Monitor: channel resets every cycle, read responses against the queue
  logic [63:0] last_rdata = 64'h0;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int c = 0; c < NUM_CH; c++)
        chk($sformatf("mem_ch_rst_n[%0d]", c), 64'(mem_ch_rst_n[c]),
            64'(released && low_left[c] == 0));
      if (!rst_n) begin
        chk("reset_rvalid", 64'(csr_rvalid), 64'h0);
        chk("reset_rdata", csr_rdata, 64'h0);
        last_rdata = 64'h0;
      end else if (csr_rvalid) begin
        if (exp_q.size() == 0 || exp_q[0].t_due != $time) begin
          chk("rvalid_spurious", 64'h1, 64'h0);
        end else begin
          rd_exp_t e;
          e = exp_q.pop_front();
          chk("rdata", csr_rdata, e.d);
          last_rdata = e.d;
        end
      end else begin
        if (exp_q.size() != 0 && exp_q[0].t_due <= $time) begin
          chk("rvalid_missing", 64'h0, 64'h1);
          void'(exp_q.pop_front());
        end
        chk("rdata_hold", csr_rdata, last_rdata);
      end
    end
  end

  initial begin
    model_reset();
    do_reset(3);

    // Identity and decode
    step(1'b1, 1'b0, 8'h00, 64'h0);
    step(1'b1, 1'b0, 8'h10, 64'h0);
    step(1'b1, 1'b0, 8'h30, 64'h0);
    step(1'b1, 1'b0, 8'h18, 64'h0);
    step(1'b1, 1'b0, 8'h0D, 64'h0);
    step(1'b0, 1'b1, 8'h30, 64'h3);       // ignored write
    idle(2);

    // Channel 0 sequence, re-request while busy, then calibration pass
    step(1'b1, 1'b1, 8'h18, 64'h1);
    idle(5);
    step(1'b0, 1'b1, 8'h18, 64'h1);
    idle(15);
    g_cs = 2'b01;
    idle(5);
    g_cs = 2'b00;
    idle(3);

    // Channel 1 with no calibration response, then clear sticky
    step(1'b0, 1'b1, 8'h18, 64'h2);
    idle(RST_PULSE + TO_CYC + 4);
    step(1'b1, 1'b1, 8'h18, 64'h8000_0000_0000_0000);
    idle(3);

    // Both channels with simultaneous pass/fail on channel 0
    step(1'b0, 1'b1, 8'h18, 64'h3);
    idle(RST_PULSE + 2);
    g_cs = 2'b01; g_cf = 2'b01;
    idle(6);
    g_cs = 2'b00; g_cf = 2'b00;

    // Abort mid-pulse
    step(1'b0, 1'b1, 8'h18, 64'h1);
    idle(4);
    do_reset(2);
    idle(4);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      logic [7:0]  a;
      logic [63:0] wd;
      bit rd, wr;
      if ($urandom_range(59) == 0) g_cs[$urandom_range(NUM_CH - 1)] ^= 1'b1;
      if ($urandom_range(59) == 0) g_cf[$urandom_range(NUM_CH - 1)] ^= 1'b1;
      case ($urandom_range(6))
        0: a = 8'h00; 1: a = 8'h08; 2: a = 8'h10;
        3, 4, 5: a = 8'h18;
        default: a = 8'($urandom);
      endcase
      a[2:0] = 3'($urandom);
      rd = ($urandom_range(2) == 0);
      wr = ($urandom_range(5) == 0);
      wd = {$urandom, $urandom};
      wd[63] = ($urandom_range(7) == 0);
      if ($urandom_range(1499) == 0) do_reset(2);
      else step(rd, wr, a, wd);
    end

    g_cs = '0; g_cf = '0;
    step(1'b0, 1'b0, 8'h0, 64'h0);
    step(1'b0, 1'b0, 8'h0, 64'h0);
    @(negedge clk); #2;
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/emif_csr_mc.md
EMIF_CSR_MC -- requirements
Module: emif_csr_mc

Interface
REQ-001 Parameter NUM_CH, default 2: number of EMIF channels; legal range 1..8.
REQ-002 Parameter CH_PRESENT, default 8'h03: channel-present mask; bits at and above NUM_CH SHALL be ignored.
REQ-003 Parameter RST_PULSE_CYCLES, default 16: duration, in cycles, that a channel reset is held low; legal range >= 2.
REQ-004 Parameter CAL_TIMEOUT_CYCLES, default 32'd1_000_000: calibration wait limit, used only when the timeout feature is compiled in (REQ-021).
REQ-005 Parameter DFH_NEXT_OFFSET, default 24'h00B000: DFH next-feature offset. Parameter DFH_EOL, default 1'b0: DFH end-of-list bit.
REQ-006 Port clk, input, 1: single clock for all logic. Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Ports csr_write and csr_read, input, 1 each: access strobes.
REQ-008 Port csr_addr, input, 8: byte address, 64-bit aligned; bits [2:0] SHALL be ignored.
REQ-009 Port csr_wdata, input, 64: write data. Port csr_rdata, output, 64: read data. Port csr_rvalid, output, 1: read-data-valid strobe.
REQ-010 Port cal_success_i, input, NUM_CH: per-channel calibration-pass level; asynchronous to clk.
REQ-011 Port cal_fail_i, input, NUM_CH: per-channel calibration-fail level; asynchronous to clk.
REQ-012 Port mem_ch_rst_n, output, NUM_CH: per-channel active-low EMIF reset.

Function
REQ-013 Address map: 0x00 DFH (read-only); 0x08 STATUS (read-only); 0x10 CAPABILITY (read-only); 0x18 CONTROL (write-only, reads as 0); all other addresses read as 0, and writes to them SHALL be ignored.
REQ-014 DFH = {4'h3, 8'h0, 4'h0, 7'h0, DFH_EOL, DFH_NEXT_OFFSET, 4'h1, 12'h009}; with the default parameters this is 64'h3_00000_00B000_1009.
REQ-015 STATUS fields: [7:0] synchronised cal_success; [15:8] synchronised cal_fail; [23:16] per-channel busy; [31:24] sticky per-channel timeout. Bits at and above NUM_CH in each field, and [63:32], SHALL read 0.
REQ-016 CAPABILITY = {24'h0, NUM_CH[7:0], 24'h0, CH_PRESENT[7:0] masked to NUM_CH}.
REQ-017 Read latency: csr_rdata and csr_rvalid are valid exactly 1 cycle after csr_read; csr_rvalid SHALL be a single-cycle pulse; csr_rdata SHALL hold its value between reads.
REQ-018 CONTROL write: bit [i] = 1 for a present channel in IDLE starts that channel's reset sequence; the request SHALL be ignored if the channel is busy or not present. Bit [63] = 1 clears all sticky timeout bits.
REQ-019 cal_success_i and cal_fail_i SHALL each pass through a 2-flop synchroniser before any use.
REQ-020 Per-channel FSM:
- IDLE: mem_ch_rst_n=1 -> RST on an accepted request.
- RST: mem_ch_rst_n=0 for exactly RST_PULSE_CYCLES cycles -> WAIT_CAL.
- WAIT_CAL: mem_ch_rst_n=1 -> IDLE on synchronised success or fail.
- busy = (state != IDLE).
REQ-021 A timeout in WAIT_CAL occurs after CAL_TIMEOUT_CYCLES cycles with neither success nor fail; it SHALL set the channel's sticky timeout bit and return the FSM to IDLE.
REQ-022 Simultaneous events: a read and a write in the same cycle SHALL both be serviced, and the read returns pre-write state. A timeout set and a clear in the same cycle SHALL resolve as set wins. Success and fail asserted together SHALL exit WAIT_CAL normally.

Reset
REQ-023 During rst_n=0: all FSMs in IDLE, mem_ch_rst_n=0, csr_rvalid=0, csr_rdata=0, synchronisers and sticky bits 0, counters 0.
REQ-024 The first clk edge after rst_n deasserts SHALL drive mem_ch_rst_n to all-ones.
REQ-025 Reset asserted mid-sequence SHALL abort every channel immediately, with no completion pulse.

Configuration
REQ-026 Macro EMIF_CSR_CAL_TIMEOUT_EN: when defined, the timeout counter and the sticky bits of REQ-021 are present. When undefined, WAIT_CAL waits indefinitely, STATUS[31:24] reads 0, and CONTROL[63] has no effect.

Structure
REQ-027 Package emif_csr_pkg SHALL hold:
- the t_dfh struct;
- the address offsets;
- the feature ID 12'h009, feature type 4'h3 and major version 4'h1;
- the FSM state enum.
REQ-028 Sub-module emif_ch_rst_fsm (one FSM, its pulse counter and its timeout counter) SHALL be instantiated NUM_CH times via a generate loop.

Verification
REQ-029 Release reset, read 0x00 -> csr_rvalid exactly 1 cycle later with data 64'h3_00000_00B000_1009.
REQ-030 NUM_CH=2, read 0x10 -> 64'h0000_0002_0000_0003; read 0x30 -> 0.
REQ-031 Write 0x18 = 0x1 -> mem_ch_rst_n[0] low for exactly 16 cycles and STATUS[16]=1; then raise cal_success_i[0] -> STATUS[0]=1 and STATUS[16]=0 within 3 cycles.
REQ-032 Macro defined, CAL_TIMEOUT_CYCLES=100, start channel 1 with no cal response -> STATUS[25]=1 and channel 1 back in IDLE; write bit [63] -> STATUS[25]=0.
REQ-033 Write 0x18 = 0x1 again while channel 0 is busy -> no new pulse; assert rst_n=0 during RST -> mem_ch_rst_n=0 and STATUS=0 after release.
